// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter
// Shares the ROB's single writeback port between the out-of-order execution
// units (0 = ALU, 1 = LSU, 2 = branch). Each requester owns a one-entry
// holding buffer. A round-robin pointer picks one buffered completion per
// cycle, and that completion is driven to the ROB from a registered output
// stage. A flush discards everything that is buffered and silences the port,
// so no stale completion reaches a flushed ROB.

module rob_wb_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int ROB_IDX_W = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           flush_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]   req_rob_idx_i,
  input  logic [NUM_REQ*32-1:0]          req_result_i,
  input  logic [NUM_REQ*32-1:0]          req_new_pc_i,
  input  logic [NUM_REQ-1:0]             req_branch_taken_i,
  output logic                           valid_wb_o,
  output logic [ROB_IDX_W-1:0]           rob_entry_commit_o,
  output logic [31:0]                    result_o,
  output logic [31:0]                    new_pc_o,
  output logic                           branch_taken_o,
  output logic [$clog2(NUM_REQ+1)-1:0]   pending_o
);

  // Pointer width is kept at one bit or more, so a single-requester build
  // still elaborates.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_REQ + 1);

  // Holding buffers, one entry per requester
  logic [NUM_REQ-1:0]   r_buf_valid;
  logic [ROB_IDX_W-1:0] r_buf_idx    [NUM_REQ];
  logic [31:0]          r_buf_result [NUM_REQ];
  logic [31:0]          r_buf_new_pc [NUM_REQ];
  logic                 r_buf_taken  [NUM_REQ];

  // Round-robin pointer: the requester that is searched first
  logic [PTR_W-1:0]     r_rr_ptr;

  // Registered writeback stage
  logic                 r_valid_wb;
  logic [ROB_IDX_W-1:0] r_wb_idx;
  logic [31:0]          r_wb_result;
  logic [31:0]          r_wb_new_pc;
  logic                 r_wb_taken;
  logic [CNT_W-1:0]     r_pending;

  // Unpacked views of the flat request buses
  logic [ROB_IDX_W-1:0] w_in_idx    [NUM_REQ];
  logic [31:0]          w_in_result [NUM_REQ];
  logic [31:0]          w_in_new_pc [NUM_REQ];

  // Arbitration and next-state signals
  logic [PTR_W-1:0]     w_cand;
  logic                 w_grant_valid;
  logic [PTR_W-1:0]     w_grant_idx;
  logic [PTR_W-1:0]     w_rr_next;
  logic [NUM_REQ-1:0]   w_ready;
  logic [NUM_REQ-1:0]   w_accept;
  logic [NUM_REQ-1:0]   w_clear;
  logic [NUM_REQ-1:0]   w_buf_valid_nxt;
  logic [CNT_W-1:0]     w_pending_nxt;

  // Number of set bits in a requester mask
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REQ-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt = cnt + CNT_W'(vec[i]);
    end
    return cnt;
  endfunction

  // Slice the flat per-requester buses into arrays indexed by requester
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_in_idx[i]    = req_rob_idx_i[i*ROB_IDX_W +: ROB_IDX_W];
      w_in_result[i] = req_result_i[i*32 +: 32];
      w_in_new_pc[i] = req_new_pc_i[i*32 +: 32];
    end
  end

  // Ready depends only on buffer occupancy, flush and reset, never on
  // req_valid_i, so requesters can form valid from ready without a loop.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = rstn_i && !flush_i && !r_buf_valid[i];
    end
  end

  assign req_ready_o = w_ready;

  // Round-robin search: scan from r_rr_ptr upward with wrap; the first
  // occupied buffer wins.
  always_comb begin
    w_cand        = '0;
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PTR_W'((32'(r_rr_ptr) + 32'(k)) % 32'(NUM_REQ));
      if (!w_grant_valid && r_buf_valid[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = w_cand;
      end
    end
  end

  // After a grant, the pointer moves to the requester just past the winner
  always_comb begin
    w_rr_next = r_rr_ptr;
    if (w_grant_valid) begin
      if (w_grant_idx == PTR_W'(NUM_REQ - 1)) begin
        w_rr_next = '0;
      end else begin
        w_rr_next = w_grant_idx + PTR_W'(1);
      end
    end
  end

  // Buffer occupancy after this edge. A granted buffer is cleared, and an
  // accepted request sets its buffer. Both can never hit the same buffer in
  // one cycle, because a granted buffer is occupied and so shows not-ready.
  always_comb begin
    w_accept = req_valid_i & w_ready;
    w_clear  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_clear[i] = w_grant_valid && (w_grant_idx == PTR_W'(i));
    end
    w_buf_valid_nxt = (r_buf_valid & ~w_clear) | w_accept;
    w_pending_nxt   = popcount(w_buf_valid_nxt);
  end

  // Buffer payloads load on accept. They carry no reset because r_buf_valid
  // qualifies every read of them.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept[i]) begin
        r_buf_idx[i]    <= w_in_idx[i];
        r_buf_result[i] <= w_in_result[i];
        r_buf_new_pc[i] <= w_in_new_pc[i];
        r_buf_taken[i]  <= req_branch_taken_i[i];
      end
    end
  end

  // Occupancy, pointer and pending count. Reset comes first, then flush,
  // which drops every buffered completion and restarts the search at
  // requester 0.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_buf_valid <= '0;
      r_rr_ptr    <= '0;
      r_pending   <= '0;
    end else if (flush_i) begin
      r_buf_valid <= '0;
      r_rr_ptr    <= '0;
      r_pending   <= '0;
    end else begin
      r_buf_valid <= w_buf_valid_nxt;
      r_rr_ptr    <= w_rr_next;
      r_pending   <= w_pending_nxt;
    end
  end

  // Writeback stage. The winner's fields are registered toward the ROB.
  // With no winner, the valid bit drops and the data fields hold their
  // previous values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_valid_wb  <= 1'b0;
      r_wb_idx    <= '0;
      r_wb_result <= '0;
      r_wb_new_pc <= '0;
      r_wb_taken  <= 1'b0;
    end else if (flush_i) begin
      r_valid_wb  <= 1'b0;
    end else if (w_grant_valid) begin
      r_valid_wb  <= 1'b1;
      r_wb_idx    <= r_buf_idx[w_grant_idx];
      r_wb_result <= r_buf_result[w_grant_idx];
      r_wb_new_pc <= r_buf_new_pc[w_grant_idx];
      r_wb_taken  <= r_buf_taken[w_grant_idx];
    end else begin
      r_valid_wb  <= 1'b0;
    end
  end

  assign valid_wb_o         = r_valid_wb;
  assign rob_entry_commit_o = r_wb_idx;
  assign result_o           = r_wb_result;
  assign new_pc_o           = r_wb_new_pc;
  assign branch_taken_o     = r_wb_taken;
  assign pending_o          = r_pending;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// tb_rob_wb_arbiter
// Self-checking bench for rob_wb_arbiter. A behavioural model tracks three
// holding slots, a round-robin start position and the writeback register.
// Every cycle, all DUT outputs are compared with the model. Directed
// scenarios add literal expectations, and a randomized phase follows them.

module tb_rob_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int IDX_W   = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic [2:0]  reqValid;
  logic [2:0]  reqReady;
  logic [11:0] reqIdx;
  logic [95:0] reqResult;
  logic [95:0] reqPc;
  logic [2:0]  reqTaken;
  logic        validWb;
  logic [3:0]  robEntry;
  logic [31:0] resultOut;
  logic [31:0] pcOut;
  logic        takenOut;
  logic [1:0]  pending;

  // Per-requester payloads the stimulus presents
  logic [3:0]  stimIdx   [NUM_REQ];
  logic [31:0] stimRes   [NUM_REQ];
  logic [31:0] stimPc    [NUM_REQ];
  logic        stimTaken [NUM_REQ];

  // Behavioural model state
  bit          mValid    [NUM_REQ];
  logic [3:0]  mIdx      [NUM_REQ];
  logic [31:0] mRes      [NUM_REQ];
  logic [31:0] mPc       [NUM_REQ];
  bit          mTaken    [NUM_REQ];
  bit          mAccepted [NUM_REQ];
  int          mRr;
  bit          mVwb;
  logic [3:0]  mOutIdx;
  logic [31:0] mOutRes;
  logic [31:0] mOutPc;
  bit          mOutTaken;
  int          mPending;

  logic [2:0]  lastReady;
  int          checkCount = 0;
  int          errCount   = 0;

  rob_wb_arbiter #(.NUM_REQ(NUM_REQ), .ROB_IDX_W(IDX_W)) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .flush_i            (flush),
    .req_valid_i        (reqValid),
    .req_ready_o        (reqReady),
    .req_rob_idx_i      (reqIdx),
    .req_result_i       (reqResult),
    .req_new_pc_i       (reqPc),
    .req_branch_taken_i (reqTaken),
    .valid_wb_o         (validWb),
    .rob_entry_commit_o (robEntry),
    .result_o           (resultOut),
    .new_pc_o           (pcOut),
    .branch_taken_o     (takenOut),
    .pending_o          (pending)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point; every check increments the counters here
  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every registered DUT output against the model
  task automatic checkOutput();
    checkVal("valid_wb",     32'(validWb),   32'(mVwb));
    checkVal("rob_entry",    32'(robEntry),  32'(mOutIdx));
    checkVal("result",       resultOut,      mOutRes);
    checkVal("new_pc",       pcOut,          mOutPc);
    checkVal("branch_taken", 32'(takenOut),  32'(mOutTaken));
    checkVal("pending",      32'(pending),   32'(mPending));
  endtask

  task automatic setPayload(input int r, input logic [3:0] idx, input logic [31:0] res,
                            input logic [31:0] pc, input logic tk);
    stimIdx[r]   = idx;
    stimRes[r]   = res;
    stimPc[r]    = pc;
    stimTaken[r] = tk;
  endtask

  // Model one clock edge from the current inputs
  task automatic modelStep(input logic [2:0] v, input logic f, input logic rn);
    bit ready [NUM_REQ];
    int winner;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i]     = rn && !f && !mValid[i];
      mAccepted[i] = 1'b0;
    end
    if (!rn) begin
      for (int i = 0; i < NUM_REQ; i++) mValid[i] = 1'b0;
      mRr = 0; mVwb = 1'b0; mOutIdx = '0; mOutRes = '0; mOutPc = '0;
      mOutTaken = 1'b0; mPending = 0;
    end else if (f) begin
      for (int i = 0; i < NUM_REQ; i++) mValid[i] = 1'b0;
      mRr = 0; mVwb = 1'b0; mPending = 0;
    end else begin
      winner = -1;
      for (int k = 0; k < NUM_REQ; k++) begin
        int j;
        j = (mRr + k) % NUM_REQ;
        if (winner < 0 && mValid[j]) winner = j;
      end
      if (winner >= 0) begin
        mVwb      = 1'b1;
        mOutIdx   = mIdx[winner];
        mOutRes   = mRes[winner];
        mOutPc    = mPc[winner];
        mOutTaken = mTaken[winner];
        mValid[winner] = 1'b0;
        mRr = (winner + 1) % NUM_REQ;
      end else begin
        mVwb = 1'b0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (v[i] && ready[i]) begin
          mValid[i]    = 1'b1;
          mIdx[i]      = stimIdx[i];
          mRes[i]      = stimRes[i];
          mPc[i]       = stimPc[i];
          mTaken[i]    = stimTaken[i];
          mAccepted[i] = 1'b1;
        end
      end
      mPending = 0;
      for (int i = 0; i < NUM_REQ; i++) mPending += int'(mValid[i]);
    end
  endtask

  // Drive one cycle of inputs (from the falling edge), check ready, advance
  // the model, then check the outputs at the next falling edge.
  task automatic applyStimulus(input logic [2:0] v, input logic f, input logic rn);
    logic [2:0] expReady;
    reqValid = v;
    flush    = f;
    rstn     = rn;
    for (int i = 0; i < NUM_REQ; i++) begin
      reqIdx[i*4 +: 4]     = stimIdx[i];
      reqResult[i*32 +: 32] = stimRes[i];
      reqPc[i*32 +: 32]    = stimPc[i];
      reqTaken[i]          = stimTaken[i];
    end
    #1;
    for (int i = 0; i < NUM_REQ; i++) expReady[i] = rn && !f && !mValid[i];
    lastReady = reqReady;
    checkVal("req_ready", 32'(reqReady), 32'(expReady));
    modelStep(v, f, rn);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int seq [2];
    int prevId;
    int pulses;
    for (int r = 0; r < NUM_REQ; r++) setPayload(r, 4'h0, 32'h0, 32'h0, 1'b0);

    // Reset
    applyStimulus(3'b000, 1'b0, 1'b0);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkVal("reset_valid_wb", 32'(validWb), 32'd0);
    checkVal("reset_pending",  32'(pending), 32'd0);

    // Single completion from the ALU
    setPayload(0, 4'd0, 32'hDEADBEEF, 32'h8, 1'b0);
    applyStimulus(3'b001, 1'b0, 1'b1);
    checkVal("single_pend1",  32'(pending), 32'd1);
    checkVal("single_vwb0",   32'(validWb), 32'd0);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("single_vwb",    32'(validWb),  32'd1);
    checkVal("single_idx",    32'(robEntry), 32'd0);
    checkVal("single_result", resultOut,     32'hDEADBEEF);
    checkVal("single_pc",     pcOut,         32'h8);
    checkVal("single_taken",  32'(takenOut), 32'd0);
    checkVal("single_pend0",  32'(pending),  32'd0);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("single_vwb_off", 32'(validWb), 32'd0);

    // Three-way contention, starting from pointer 0 after a flush
    applyStimulus(3'b000, 1'b1, 1'b1);
    setPayload(0, 4'd1, 32'h1111_0001, 32'h100, 1'b0);
    setPayload(1, 4'd2, 32'h2222_0002, 32'h200, 1'b0);
    setPayload(2, 4'd3, 32'h3333_0003, 32'h300, 1'b1);
    applyStimulus(3'b111, 1'b0, 1'b1);
    checkVal("three_pend3", 32'(pending), 32'd3);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(3'b000, 1'b0, 1'b1);
      checkVal("three_vwb",  32'(validWb),  32'd1);
      checkVal("three_idx",  32'(robEntry), 32'(n + 1));
      checkVal("three_pend", 32'(pending),  32'(2 - n));
    end
    checkVal("three_taken", 32'(takenOut), 32'd1);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("three_vwb_off", 32'(validWb), 32'd0);

    // Fairness: ALU and LSU hold valid continuously, so grants must alternate.
    // The requester id travels in the top nibble of the result.
    seq[0] = 0; seq[1] = 0;
    for (int r = 0; r < 2; r++) setPayload(r, 4'(seq[r]), {4'(r), 28'(seq[r])}, 32'(seq[r]), 1'b0);
    prevId = -1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(3'b011, 1'b0, 1'b1);
      if (validWb) begin
        pulses++;
        if (prevId < 0) checkVal("rr_first_alu", 32'(resultOut[31:28]), 32'd0);
        else checkVal("rr_alternate", 32'(int'(resultOut[31:28]) != prevId), 32'd1);
        prevId = int'(resultOut[31:28]);
      end
      for (int r = 0; r < 2; r++) begin
        if (mAccepted[r]) begin
          seq[r]++;
          setPayload(r, 4'(seq[r]), {4'(r), 28'(seq[r])}, 32'(seq[r]), 1'b0);
        end
      end
    end
    checkVal("rr_pulses", 32'(pulses), 32'd11);

    // Backpressure: the ALU entry waits behind LSU and branch
    applyStimulus(3'b000, 1'b1, 1'b1);
    setPayload(1, 4'd5, 32'h5555, 32'h50, 1'b0);
    setPayload(2, 4'd6, 32'h6666, 32'h60, 1'b1);
    applyStimulus(3'b110, 1'b0, 1'b1);
    checkVal("bp_pend2", 32'(pending), 32'd2);
    setPayload(0, 4'd7, 32'h111, 32'h70, 1'b0);
    applyStimulus(3'b001, 1'b0, 1'b1);
    checkVal("bp_ready_first", 32'(lastReady[0]), 32'd1);
    checkVal("bp_idx_lsu",     32'(robEntry),     32'd5);
    setPayload(0, 4'd8, 32'h222, 32'h80, 1'b0);
    applyStimulus(3'b001, 1'b0, 1'b1);
    checkVal("bp_ready_held1", 32'(lastReady[0]), 32'd0);
    checkVal("bp_idx_br",      32'(robEntry),     32'd6);
    applyStimulus(3'b001, 1'b0, 1'b1);
    checkVal("bp_ready_held2", 32'(lastReady[0]), 32'd0);
    checkVal("bp_idx_p1",      32'(robEntry),     32'd7);
    checkVal("bp_res_p1",      resultOut,         32'h111);
    applyStimulus(3'b001, 1'b0, 1'b1);
    checkVal("bp_ready_again", 32'(lastReady[0]), 32'd1);
    checkVal("bp_gap_vwb",     32'(validWb),      32'd0);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("bp_idx_p2",      32'(robEntry),     32'd8);
    checkVal("bp_res_p2",      resultOut,         32'h222);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("bp_no_dup",      32'(validWb),      32'd0);

    // Flush with all buffers full and a new ALU valid in the same cycle
    setPayload(0, 4'd9,  32'h9,  32'h90, 1'b0);
    setPayload(1, 4'd10, 32'hA,  32'hA0, 1'b0);
    setPayload(2, 4'd11, 32'hB,  32'hB0, 1'b0);
    applyStimulus(3'b111, 1'b0, 1'b1);
    checkVal("fl_pend3", 32'(pending), 32'd3);
    setPayload(0, 4'd12, 32'hBAD, 32'hC0, 1'b0);
    applyStimulus(3'b001, 1'b1, 1'b1);
    checkVal("fl_ready",  32'(lastReady), 32'd0);
    checkVal("fl_vwb",    32'(validWb),   32'd0);
    checkVal("fl_pend0",  32'(pending),   32'd0);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("fl_dropped", 32'(validWb), 32'd0);
    setPayload(0, 4'd13, 32'hD, 32'hD0, 1'b0);
    setPayload(1, 4'd14, 32'hE, 32'hE0, 1'b0);
    applyStimulus(3'b011, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("fl_rr_zero_alu", 32'(robEntry), 32'd13);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("fl_rr_then_lsu", 32'(robEntry), 32'd14);

    // Reset with two buffers still pending
    setPayload(0, 4'd1, 32'h10, 32'h11, 1'b1);
    setPayload(1, 4'd2, 32'h20, 32'h21, 1'b1);
    setPayload(2, 4'd3, 32'h30, 32'h31, 1'b1);
    applyStimulus(3'b111, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("rst_pre_pend2", 32'(pending), 32'd2);
    applyStimulus(3'b000, 1'b0, 1'b0);
    checkVal("rst_ready",  32'(lastReady), 32'd0);
    checkVal("rst_vwb",    32'(validWb),   32'd0);
    checkVal("rst_idx",    32'(robEntry),  32'd0);
    checkVal("rst_result", resultOut,      32'd0);
    checkVal("rst_pc",     pcOut,          32'd0);
    checkVal("rst_taken",  32'(takenOut),  32'd0);
    checkVal("rst_pend",   32'(pending),   32'd0);
    applyStimulus(3'b111, 1'b0, 1'b0);
    checkVal("rst_ready_hold", 32'(lastReady), 32'd0);
    applyStimulus(3'b000, 1'b0, 1'b1);
    checkVal("rst_no_leftover", 32'(validWb), 32'd0);

    // Randomized traffic with occasional flushes and resets
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        setPayload(r, 4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, 29) == 0, $urandom_range(0, 99) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
